// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - first-word-fall-through byte FIFO for UART TX/RX paths
//
// Purpose: buffers bytes between a producer (bus write path or UART RX
// deserialiser) and a consumer, with a registered fill level, a synchronous
// flush and a sticky overflow flag.
//
// Ports:
//   clk_i       single clock, all state changes on its rising edge
//   rst_ni      asynchronous active-low reset
//   flush_i     synchronous discard of all stored bytes and the overflow flag
//   wr_data_i   byte offered by the producer
//   wr_valid_i  producer offers wr_data_i
//   wr_ready_o  FIFO accepts a byte this cycle
//   rd_data_o   head byte (8'h00 whenever rd_valid_o is low)
//   rd_valid_o  head byte is valid
//   rd_ready_i  consumer takes the head byte
//   level_o     number of stored bytes, 0..DEPTH
//   overflow_o  sticky: producer was stalled while the FIFO was full
//   ovf_clr_i   clears overflow_o (a simultaneous set wins)
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [7:0]    wr_data_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    output logic [7:0]    rd_data_o,
    output logic          rd_valid_o,
    input  logic          rd_ready_i,
    output logic [AW:0]   level_o,
    output logic          overflow_o,
    input  logic          ovf_clr_i
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;
    logic w_ovf_set;

    assign w_full  = (r_level == FULL_LVL);
    assign w_empty = (r_level == '0);

    // Full is judged on the registered level only, so a read in the same
    // cycle never opens the write; the stalled byte goes in one cycle later.
    assign w_wr      = wr_valid_i && !w_full && !flush_i;
    assign w_rd      = !w_empty && rd_ready_i && !flush_i;
    assign w_ovf_set = wr_valid_i && w_full && !flush_i;

    // Ready reads high throughout reset, when the FIFO is empty by definition.
    assign wr_ready_o = !rst_ni || (!w_full && !flush_i);
    assign rd_valid_o = !w_empty;
    assign rd_data_o  = w_empty ? 8'h00 : r_mem[r_rptr];
    assign level_o    = r_level;
    assign overflow_o = r_ovf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset; rd_data_o masks it while empty.
    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_uart_byte_fifo.sv
// tb/tb_uart_byte_fifo.sv - randomized, model-checked bench for uart_byte_fifo
module tb_uart_byte_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic [7:0]    wr_data_i;
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [7:0]    rd_data_o;
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [AW:0]   level_o;
    logic          overflow_o;
    logic          ovf_clr_i;

    int checks = 0;
    int errors = 0;

    int mq[$];
    int rd_log[$];
    bit m_ovf = 1'b0;
    bit chk_en = 1'b0;

    uart_byte_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .wr_data_i  (wr_data_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored bytes plus the sticky flag.
    always @(negedge rst_ni) begin
        mq.delete();
        m_ovf = 1'b0;
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (flush_i) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                bit full;
                bit do_rd;
                bit do_wr;
                full  = (mq.size() == DEPTH);
                do_rd = (mq.size() != 0) && rd_ready_i;
                do_wr = wr_valid_i && !full;
                if (do_rd) rd_log.push_back(mq.pop_front());
                if (do_wr) mq.push_back(int'(wr_data_i));
                if (wr_valid_i && full) m_ovf = 1'b1;
                else if (ovf_clr_i)     m_ovf = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("level",      int'(level_o),    mq.size());
            check("rd_valid",   int'(rd_valid_o), int'(mq.size() != 0));
            check("rd_data",    int'(rd_data_o),  (mq.size() != 0) ? mq[0] : 0);
            check("wr_ready",   int'(wr_ready_o),
                  int'(!rst_ni || (mq.size() != DEPTH && !flush_i)));
            check("overflow",   int'(overflow_o), int'(m_ovf));
        end
    end

    // Inputs set 1 time unit after a rising edge; they take effect at the next one.
    task automatic drive(input bit wv, input bit [7:0] wd, input bit rr,
                         input bit fl, input bit oc);
        @(posedge clk_i);
        #1;
        wr_valid_i = wv;
        wr_data_i  = wd;
        rd_ready_i = rr;
        flush_i    = fl;
        ovf_clr_i  = oc;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int exp_drain[$];
        bit saw_aa;

        rst_ni     = 1'b0;
        flush_i    = 1'b0;
        wr_data_i  = 8'h00;
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        ovf_clr_i  = 1'b0;
        #23;
        check("reset_level",    int'(level_o),    0);
        check("reset_wr_ready", int'(wr_ready_o), 1);
        check("reset_rd_data",  int'(rd_data_o),  0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Fill 0x01..0x10 with no reads.
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        idle();
        #2;
        check("fill_level",    int'(level_o),    16);
        check("fill_wr_ready", int'(wr_ready_o), 0);
        check("fill_head",     int'(rd_data_o),  8'h01);

        // Overflow: 0xAA offered for three cycles while full.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        idle();
        #2;
        check("ovf_set",   int'(overflow_o), 1);
        check("ovf_level", int'(level_o),    16);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle();
        #2;
        check("ovf_clr", int'(overflow_o), 0);

        // Full plus read: write 0x55 stalls one cycle, then goes in.
        rd_log.delete();
        drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        #2;
        check("fullrd_level_mid", int'(level_o), 15);
        idle();
        #2;
        check("fullrd_level_end", int'(level_o), 16);

        // Drain everything.
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle();
        #2;
        check("drain_level", int'(level_o),    0);
        check("drain_valid", int'(rd_valid_o), 0);
        for (int i = 1; i <= 16; i++) exp_drain.push_back(i);
        exp_drain.push_back(8'h55);
        check("drain_count", rd_log.size(), exp_drain.size());
        saw_aa = 1'b0;
        for (int i = 0; i < rd_log.size(); i++) begin
            if (i < exp_drain.size()) check("drain_order", rd_log[i], exp_drain[i]);
            if (rd_log[i] == 8'hAA) saw_aa = 1'b1;
        end
        check("aa_never_read", int'(saw_aa), 0);

        // Simultaneous traffic at level 5 across pointer wrap.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
        idle();
        #2;
        check("simul_level", int'(level_o), 5);

        // Flush at level 7 with overflow set, concurrent write of 0x33.
        for (int i = 0; i < 11; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        #2;
        check("preflush_level", int'(level_o),    7);
        check("preflush_ovf",   int'(overflow_o), 1);
        check("flush_ready",    int'(wr_ready_o), 0);
        idle();
        #2;
        check("flush_level", int'(level_o),    0);
        check("flush_ovf",   int'(overflow_o), 0);
        check("flush_valid", int'(rd_valid_o), 0);

        // Randomized traffic with occasional flush and overflow clear.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0));
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-drain at level 9.
        for (int i = 0; i < 12; i++) drive(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #2;
        check("prereset_level", int'(level_o), 9);
        #1;
        rst_ni = 1'b0;
        #1;
        check("areset_level",    int'(level_o),    0);
        check("areset_valid",    int'(rd_valid_o), 0);
        check("areset_data",     int'(rd_data_o),  0);
        check("areset_wr_ready", int'(wr_ready_o), 1);
        check("areset_ovf",      int'(overflow_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        rd_ready_i = 1'b0;
        drive(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);
        idle();
        #2;
        check("post_reset_data",  int'(rd_data_o), 8'h7E);
        check("post_reset_level", int'(level_o),   1);
        idle();
        idle();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
